// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI master (spi_master_cfg, spi_clkgen).
//   spi_state_t : transfer FSM states
//   spi_mode_t  : {cpol, cpha} captured when a request is accepted
//   cnt_width() : counter width for a modulus n, never less than one bit
package spi_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StXfer,
      StHold,
      StDone
   } spi_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period tick generator for the SPI master.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : synchronous restart of the count (request accepted)
//   en   : count while high
//   tick : one-cycle pulse every NT enabled cycles
module spi_clkgen
   import spi_pkg::*;
#(
   parameter int unsigned NT = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = cnt_width(NT);
   localparam logic [CW-1:0] LAST = CW'(NT - 1);

   logic [CW-1:0] cnt_q;

   assign tick = en && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tick ? '0 : cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: mode-configurable SPI master with decoded chip selects.
// Everything runs in the clk domain; sclk is a registered output, never a clock.
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   start, ready, busy: request handshake (start accepted only while ready)
//   cs_sel, cpol, cpha, din : transfer parameters, captured on accept
//   done, dout        : one-cycle completion pulse, received word held until next done
//   sclk, mosi, miso  : SPI bus (miso pre-synchronised)
//   cs_n              : active-low chip selects, cs_sel >= NCS asserts none
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift LSB-first in both directions.
module spi_master_cfg
   import spi_pkg::*;
#(
   parameter int unsigned CLKFREQ = 27000000,
   parameter int unsigned SPIFREQ = 100000,
   parameter int unsigned WIDTH   = 13,
   parameter int unsigned NCS     = 4,
   localparam int unsigned CSW    = cnt_width(NCS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CSW-1:0]   cs_sel,
   input  logic             cpol,
   input  logic             cpha,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout,
   output logic             sclk,
   output logic             mosi,
   input  logic             miso,
   output logic [NCS-1:0]   cs_n
);

   localparam int unsigned NT  = CLKFREQ / (2 * SPIFREQ);
   localparam int unsigned HCW = cnt_width(2 * WIDTH);
   localparam logic [HCW-1:0] HLAST = HCW'(2 * WIDTH - 1);

   if (NT < 1) begin : g_nt_check
      $error("spi_master_cfg: CLKFREQ/(2*SPIFREQ) must be at least 1");
   end
   if (WIDTH < 2) begin : g_width_check
      $error("spi_master_cfg: WIDTH must be at least 2");
   end

   function automatic logic tx_head(input logic [WIDTH-1:0] v);
`ifdef SPI_MASTER_LSB_FIRST_EN
      return v[0];
`else
      return v[WIDTH-1];
`endif
   endfunction

   function automatic logic [WIDTH-1:0] tx_adv(input logic [WIDTH-1:0] v);
`ifdef SPI_MASTER_LSB_FIRST_EN
      return v >> 1;
`else
      return v << 1;
`endif
   endfunction

   function automatic logic [WIDTH-1:0] rx_push(input logic [WIDTH-1:0] v, input logic b);
`ifdef SPI_MASTER_LSB_FIRST_EN
      return {b, v[WIDTH-1:1]};
`else
      return {v[WIDTH-2:0], b};
`endif
   endfunction

   spi_state_t       state_q, state_d;
   spi_mode_t        mode_q, mode_d;
   logic [CSW-1:0]   cs_sel_q, cs_sel_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic [WIDTH-1:0] rx_q, rx_d;
   logic [HCW-1:0]   hcnt_q, hcnt_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [NCS-1:0]   cs_n_q, cs_n_d;
   logic             done_q, ready_q, busy_q;
   logic             accept, tick, run;

   assign run = (state_q == StSetup) || (state_q == StXfer) || (state_q == StHold);

   spi_clkgen #(
      .NT (NT)
   ) u_clkgen (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (run),
      .tick (tick)
   );

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      cs_sel_d = cs_sel_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      hcnt_d   = hcnt_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      dout_d   = dout_q;
      accept   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               accept      = 1'b1;
               state_d     = StSetup;
               mode_d.cpol = cpol;
               mode_d.cpha = cpha;
               cs_sel_d    = cs_sel;
               sclk_d      = cpol;
               hcnt_d      = '0;
               tx_d        = din;
               mosi_d      = 1'b0;
               // CPHA=0 must present the first bit before the first (sampling) edge.
               if (!cpha) begin
                  mosi_d = tx_head(din);
                  tx_d   = tx_adv(din);
               end
            end
         end
         StSetup: begin
            if (tick) begin
               state_d = StXfer;
            end
         end
         StXfer: begin
            if (tick) begin
               sclk_d = ~sclk_q;
               hcnt_d = hcnt_q + HCW'(1);
               // Even hcnt is a leading edge, odd a trailing edge.
               if (!hcnt_q[0]) begin
                  if (!mode_q.cpha) begin
                     rx_d = rx_push(rx_q, miso);
                  end else begin
                     mosi_d = tx_head(tx_q);
                     tx_d   = tx_adv(tx_q);
                  end
               end else begin
                  if (mode_q.cpha) begin
                     rx_d = rx_push(rx_q, miso);
                  end else if (hcnt_q != HLAST) begin
                     // Last trailing edge has no next bit; keep mosi steady into HOLD.
                     mosi_d = tx_head(tx_q);
                     tx_d   = tx_adv(tx_q);
                  end
                  if (hcnt_q == HLAST) begin
                     state_d = StHold;
                     sclk_d  = mode_q.cpol;
                  end
               end
            end
         end
         StHold: begin
            if (tick) begin
               state_d = StDone;
               dout_d  = rx_q;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      cs_n_d = '1;
      if ((state_d == StSetup) || (state_d == StXfer) || (state_d == StHold)) begin
         for (int i = 0; i < NCS; i++) begin
            cs_n_d[i] = (cs_sel_d != CSW'(i));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         mode_q   <= '0;
         cs_sel_q <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         hcnt_q   <= '0;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
         dout_q   <= '0;
         cs_n_q   <= '1;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cs_sel_q <= cs_sel_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         hcnt_q   <= hcnt_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
         dout_q   <= dout_d;
         cs_n_q   <= cs_n_d;
         done_q   <= (state_d == StDone);
         ready_q  <= (state_d == StIdle);
         busy_q   <= (state_d != StIdle);
      end
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign dout  = dout_q;
   assign sclk  = sclk_q;
   assign mosi  = mosi_q;
   assign cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed self-checking bench for spi_master_cfg (NT=10, WIDTH=8).
// A second instance with five chip selects is used for the out-of-range cs_sel case,
// since a 2-bit cs_sel on the four-line instance cannot carry the value 5.
module tb_spi_master_cfg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, cpol, cpha, loop_en, slave_miso;
   logic [1:0] cs_sel;
   logic [7:0] din;
   logic       ready, busy, done, sclk, mosi;
   logic [7:0] dout;
   logic [3:0] cs_n;
   wire        miso = loop_en ? mosi : slave_miso;

   logic       start5;
   logic [2:0] cs_sel5;
   logic       ready5, busy5, done5, sclk5, mosi5;
   logic [7:0] dout5;
   logic [4:0] cs_n5;

   spi_master_cfg #(
      .CLKFREQ (27000000),
      .SPIFREQ (1350000),
      .WIDTH   (8),
      .NCS     (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .cs_sel (cs_sel),
      .cpol   (cpol),
      .cpha   (cpha),
      .din    (din),
      .ready  (ready),
      .busy   (busy),
      .done   (done),
      .dout   (dout),
      .sclk   (sclk),
      .mosi   (mosi),
      .miso   (miso),
      .cs_n   (cs_n)
   );

   spi_master_cfg #(
      .CLKFREQ (27000000),
      .SPIFREQ (1350000),
      .WIDTH   (8),
      .NCS     (5)
   ) dut5 (
      .clk    (clk),
      .rst    (rst),
      .start  (start5),
      .cs_sel (cs_sel5),
      .cpol   (cpol),
      .cpha   (cpha),
      .din    (din),
      .ready  (ready5),
      .busy   (busy5),
      .done   (done5),
      .dout   (dout5),
      .sclk   (sclk5),
      .mosi   (mosi5),
      .miso   (mosi5),
      .cs_n   (cs_n5)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   int         r_done_k, r_done_n, r_rises, r_cs_bad, r_setup2_k;
   logic [7:0] r_srx, r_stx, r_dout;
   logic       r_first_mosi, r_sclk1, r_ready182;
   logic [3:0] r_post_cs;
   logic       r_post_sclk, r_post_busy, r_post_ready;
   logic [7:0] r_post_dout;

`ifdef SPI_MASTER_LSB_FIRST_EN
   localparam logic LSBF = 1'b1;
`else
   localparam logic LSBF = 1'b0;
`endif

   // One transfer on the 4-line instance, observed for 200 cycles after the accept edge.
   // Cycle k is the k-th negedge after accept; done is expected at k=181.
   task automatic run_xfer(input logic [1:0] sel, input logic pol, input logic pha,
                           input logic [7:0] data, input logic lp, input logic [7:0] sword,
                           input logic mid_start, input int rst_at, input logic hold);
      logic       prev_cs_on, cs_on, prev_sclk, rst_pend, rst_seen;
      logic [3:0] exp_cs;
      exp_cs = 4'hF;
      exp_cs[sel] = 1'b0;
      r_done_k = 0; r_done_n = 0; r_rises = 0; r_cs_bad = 0; r_setup2_k = 0;
      r_srx = 8'h00; r_stx = sword; r_dout = 8'h00; r_ready182 = 1'b0;
      slave_miso = 1'b0;
      prev_cs_on = 1'b0; prev_sclk = 1'b0; rst_pend = 1'b0; rst_seen = 1'b0;
      @(negedge clk);
      check("ready_before_start", 32'(ready), 32'd1);
      cs_sel = sel; cpol = pol; cpha = pha; din = data; loop_en = lp; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (k == 1 && !hold) start = 1'b0;
         if (rst_pend) begin
            r_post_cs = cs_n; r_post_sclk = sclk; r_post_busy = busy;
            r_post_ready = ready; r_post_dout = dout;
            rst = 1'b0; rst_pend = 1'b0; rst_seen = 1'b1;
         end
         cs_on = (cs_n != 4'hF);
         if (k == 1) begin
            r_first_mosi = mosi;
            r_sclk1 = sclk;
         end
         // Slave model: captures mosi on rising sclk, drives miso after falling sclk.
         if (cs_on && prev_cs_on && sclk != prev_sclk) begin
            if (sclk) begin
               r_rises++;
               r_srx = LSBF ? {mosi, r_srx[7:1]} : {r_srx[6:0], mosi};
            end else begin
               slave_miso = LSBF ? r_stx[0] : r_stx[7];
               r_stx = LSBF ? (r_stx >> 1) : (r_stx << 1);
            end
         end
         if (done) begin
            r_done_n++;
            if (r_done_k == 0) begin
               r_done_k = k;
               r_dout = dout;
               if (cs_n != 4'hF) r_cs_bad++;
            end
         end else if (r_done_k == 0 && !rst_seen && k <= 180 && cs_n != exp_cs) begin
            r_cs_bad++;
         end
         if (k == 182) r_ready182 = ready;
         if (r_done_k != 0 && cs_on && r_setup2_k == 0) r_setup2_k = k;
         if (mid_start && k == 50) start = 1'b1;
         if (mid_start && k == 51) start = 1'b0;
         if (rst_at != 0 && !rst_seen && !rst_pend && r_rises == rst_at) begin
            rst = 1'b1;
            rst_pend = 1'b1;
         end
         prev_cs_on = cs_on;
         prev_sclk = sclk;
      end
      start = 1'b0;
      rst = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (ready) break;
      end
      check("idle_reached", 32'(ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; start5 = 1'b0; cs_sel = 2'd0; cs_sel5 = 3'd0;
      cpol = 1'b0; cpha = 1'b0; din = 8'h00; loop_en = 1'b1; slave_miso = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_busy",  32'(busy),  32'd0);
      check("rst_done",  32'(done),  32'd0);
      check("rst_dout",  32'(dout),  32'h0);
      check("rst_sclk",  32'(sclk),  32'd0);
      check("rst_mosi",  32'(mosi),  32'd0);
      check("rst_cs_n",  32'(cs_n),  32'hF);
      rst = 1'b0;

      // Mode 0 loopback, slave 1.
      run_xfer(2'd1, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 0, 1'b0);
      check("m0_done_cycle", 32'(r_done_k), 32'd181);
      check("m0_done_count", 32'(r_done_n), 32'd1);
      check("m0_rises",      32'(r_rises),  32'd8);
      check("m0_cs_bad",     32'(r_cs_bad), 32'd0);
      check("m0_slave_rx",   32'(r_srx),    32'hA5);
      check("m0_dout",       32'(r_dout),   32'hA5);
      check("m0_first_mosi", 32'(r_first_mosi), 32'd1);

      // Mode 3 against slave returning 0x3C, slave 2.
      run_xfer(2'd2, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h3C, 1'b0, 0, 1'b0);
      check("m3_sclk_setup", 32'(r_sclk1),  32'd1);
      check("m3_done_cycle", 32'(r_done_k), 32'd181);
      check("m3_rises",      32'(r_rises),  32'd8);
      check("m3_cs_bad",     32'(r_cs_bad), 32'd0);
      check("m3_slave_rx",   32'(r_srx),    32'h5A);
      check("m3_dout",       32'(r_dout),   32'h3C);
      check("m3_sclk_idle",  32'(sclk),     32'd1);

      // start pulsed mid-XFER is ignored.
      run_xfer(2'd0, 1'b0, 1'b0, 8'h96, 1'b1, 8'h00, 1'b1, 0, 1'b0);
      check("mid_done_count", 32'(r_done_n), 32'd1);
      check("mid_done_cycle", 32'(r_done_k), 32'd181);
      check("mid_dout",       32'(r_dout),   32'h96);
      check("mid_ready_after", 32'(ready),   32'd1);

      // start held high, mode 1: one IDLE cycle then the next SETUP.
      run_xfer(2'd3, 1'b0, 1'b1, 8'h69, 1'b1, 8'h00, 1'b0, 0, 1'b1);
      check("hold_done_cycle", 32'(r_done_k),   32'd181);
      check("hold_idle_gap",   32'(r_ready182), 32'd1);
      check("hold_next_setup", 32'(r_setup2_k), 32'd183);
      check("hold_dout",       32'(r_dout),     32'h69);
      wait_idle();
      check("hold_dout2", 32'(dout), 32'h69);

      // Reset after the 4th sampling edge.
      run_xfer(2'd1, 1'b0, 1'b0, 8'hC3, 1'b1, 8'h00, 1'b0, 4, 1'b0);
      check("rst_mid_cs_n",  32'(r_post_cs),    32'hF);
      check("rst_mid_sclk",  32'(r_post_sclk),  32'd0);
      check("rst_mid_busy",  32'(r_post_busy),  32'd0);
      check("rst_mid_ready", 32'(r_post_ready), 32'd1);
      check("rst_mid_dout",  32'(r_post_dout),  32'h0);
      check("rst_mid_no_done", 32'(r_done_n),   32'd0);

      // Out-of-range select on the 5-line instance.
      @(negedge clk);
      cs_sel5 = 3'd5; din = 8'h4E; cpol = 1'b0; cpha = 1'b0; start5 = 1'b1;
      @(posedge clk);
      r_done_k = 0; r_cs_bad = 0; r_dout = 8'h00;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (k == 1) start5 = 1'b0;
         if (cs_n5 != 5'h1F) r_cs_bad++;
         if (done5 && r_done_k == 0) begin
            r_done_k = k;
            r_dout = dout5;
         end
      end
      check("sel5_cs_none",    32'(r_cs_bad), 32'd0);
      check("sel5_done_cycle", 32'(r_done_k), 32'd181);
      check("sel5_dout",       32'(r_dout),   32'h4E);

      // Bit order: 0x01 shows the LSB first only when LSB-first is built in.
      run_xfer(2'd0, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00, 1'b0, 0, 1'b0);
      check("order_first_mosi", 32'(r_first_mosi), 32'(LSBF));
      check("order_slave_rx",   32'(r_srx),        32'h01);
      check("order_dout",       32'(r_dout),       32'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
